// File: rtl/mult_hilo_unit.sv
`default_nettype none
// ============================================================================
// Module  : mult_hilo_unit
// Brief   : Multi-cycle MULT/MULTU unit (radix-2 shift-add on magnitudes with
//           final sign fix-up) owning the HI/LO register pair.
// Revision: 1.0 - initial release
// ============================================================================
module mult_hilo_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int             CW     = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  C_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_SIGN = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplr_q,  mplr_d;
  logic [WIDTH-1:0]   acc_q,   acc_d;
  logic [CW-1:0]      cnt_q,   cnt_d;
  logic               neg_q,   neg_d;
  logic [WIDTH-1:0]   hi_q,    hi_d;
  logic [WIDTH-1:0]   lo_q,    lo_d;
  logic               done_q,  done_d;

  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_prod;

  // Magnitude of the most negative value wraps to itself, which is exact as unsigned.
  assign w_abs_a = (is_signed && op_a[WIDTH-1]) ? -op_a : op_a;
  assign w_abs_b = (is_signed && op_b[WIDTH-1]) ? -op_b : op_b;

  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    mplr_d  = mplr_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    w_sum   = '0;
    w_prod  = '0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mcand_d = w_abs_a;
          mplr_d  = w_abs_b;
          neg_d   = is_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_RUN;
        end else begin
          if (mthi) hi_d = wdata;
          if (mtlo) lo_d = wdata;
        end
      end
      S_RUN: begin
        // Low product bits shift into the multiplier register as it is consumed.
        w_sum   = {1'b0, acc_q} + {1'b0, (mplr_q[0] ? mcand_q : '0)};
        acc_d   = w_sum[WIDTH:1];
        mplr_d  = {w_sum[0], mplr_q[WIDTH-1:1]};
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == C_LAST) state_d = S_SIGN;
      end
      S_SIGN: begin
        w_prod  = neg_q ? -{acc_q, mplr_q} : {acc_q, mplr_q};
        hi_d    = w_prod[2*WIDTH-1:WIDTH];
        lo_d    = w_prod[WIDTH-1:0];
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      mcand_q <= '0;
      mplr_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_mult_hilo_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_mult_hilo_unit
// Brief   : Self-checking bench: 32-bit directed/random multiplies plus an
//           exhaustive 4-bit instance, against an arithmetic reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mult_hilo_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        s_start = 0, s_sgn = 0, s_mthi = 0, s_mtlo = 0;
  logic [31:0] s_a = 0, s_b = 0, s_wd = 0;
  logic        s_busy, s_done;
  logic [31:0] s_hi, s_lo;

  logic        f_start = 0, f_sgn = 0, f_mthi = 0, f_mtlo = 0;
  logic [3:0]  f_a = 0, f_b = 0, f_wd = 0;
  logic        f_busy, f_done;
  logic [3:0]  f_hi, f_lo;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] hm = 0, lm = 0;

  always #5 clk = ~clk;

  mult_hilo_unit #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .start(s_start), .is_signed(s_sgn),
    .op_a(s_a), .op_b(s_b), .mthi(s_mthi), .mtlo(s_mtlo), .wdata(s_wd),
    .busy(s_busy), .done(s_done), .hi(s_hi), .lo(s_lo)
  );

  mult_hilo_unit #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(f_start), .is_signed(f_sgn),
    .op_a(f_a), .op_b(f_b), .mthi(f_mthi), .mtlo(f_mtlo), .wdata(f_wd),
    .busy(f_busy), .done(f_done), .hi(f_hi), .lo(f_lo)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref32(input bit sg, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    if (sg) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    return {32'b0, a} * {32'b0, b};
  endfunction

  function automatic logic [7:0] ref4(input bit sg, input logic [3:0] a, input logic [3:0] b);
    int sa, sb;
    sa = sg ? int'($signed(a)) : int'(a);
    sb = sg ? int'($signed(b)) : int'(b);
    return 8'(sa * sb);
  endfunction

  // Called on a negedge; returns on the negedge where done should be high.
  // mt_at >= 1 pulses MTHI 0x1234 during that RUN cycle.
  task automatic do_mul32(input bit sg, input logic [31:0] a, input logic [31:0] b, input int mt_at);
    logic [63:0] exp;
    int cnt;
    s_start = 1; s_sgn = sg; s_a = a; s_b = b;
    @(negedge clk);
    s_start = 0; s_mthi = 0; cnt = 0;
    while (s_busy && cnt < 100) begin
      cnt++;
      if (cnt == 10) begin
        check("hold_hi", s_hi, hm);
        check("hold_lo", s_lo, lm);
      end
      if (cnt == mt_at) begin s_mthi = 1; s_wd = 32'h1234; end
      else s_mthi = 0;
      @(negedge clk);
    end
    s_mthi = 0;
    exp = ref32(sg, a, b);
    check("busy_cycles", 64'(cnt), 64'd33);
    check("done_pulse", s_done, 1);
    check("hi", s_hi, exp[63:32]);
    check("lo", s_lo, exp[31:0]);
    hm = exp[63:32];
    lm = exp[31:0];
  endtask

  task automatic do_mul4(input bit sg, input logic [3:0] a, input logic [3:0] b);
    int cnt;
    f_start = 1; f_sgn = sg; f_a = a; f_b = b;
    @(negedge clk);
    f_start = 0; cnt = 0;
    while (f_busy && cnt < 50) begin
      cnt++;
      @(negedge clk);
    end
    check("w4_busy_cycles", 64'(cnt), 64'd5);
    check("w4_prod", {f_hi, f_lo}, ref4(sg, a, b));
  endtask

  initial begin
    int cnt;
    logic [31:0] ra, rb;
    repeat (2) @(negedge clk);
    check("rst_busy", s_busy, 0);
    check("rst_done", s_done, 0);
    check("rst_hi", s_hi, 0);
    check("rst_lo", s_lo, 0);
    check("rst4_hilo", {f_busy, f_done, f_hi, f_lo}, 0);
    rst_n = 1;
    @(negedge clk);

    do_mul32(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    do_mul32(1, 32'h80000000, 32'hFFFFFFFF, 0);  // back-to-back in done cycle
    do_mul32(1, 32'hFFFFFFFD, 32'h00000007, 0);
    do_mul32(0, 32'hFFFFFFFD, 32'h00000007, 0);
    do_mul32(1, 32'h80000000, 32'h80000000, 0);
    do_mul32(1, 32'h00000000, 32'h80000000, 0);

    // MTHI during RUN is ignored; idle MTLO lands.
    do_mul32(1, 32'h12345678, 32'h9ABCDEF0, 3);
    s_mtlo = 1; s_wd = 32'hBEEF;
    @(negedge clk);
    s_mtlo = 0;
    check("mt_done_drop", s_done, 0);
    check("mt_hi", s_hi, hm);
    check("mt_lo", s_lo, 32'hBEEF);
    lm = 32'hBEEF;

    // Both written in one idle cycle.
    s_mthi = 1; s_mtlo = 1; s_wd = 32'hCAFEF00D;
    @(negedge clk);
    s_mthi = 0; s_mtlo = 0;
    check("mthilo_hi", s_hi, 32'hCAFEF00D);
    check("mthilo_lo", s_lo, 32'hCAFEF00D);
    check("mthilo_done", s_done, 0);
    hm = 32'hCAFEF00D; lm = 32'hCAFEF00D;

    // Start together with MTHI: start wins.
    s_mthi = 1; s_wd = 32'hDEAD0000;
    do_mul32(0, 32'h0000FFFF, 32'h00010001, 0);

    // Reset mid-RUN.
    @(negedge clk);
    s_start = 1; s_sgn = 1; s_a = 32'h7FFFFFFF; s_b = 32'h00000003;
    @(negedge clk);
    s_start = 0; cnt = 0;
    while (s_busy && cnt < 10) begin cnt++; @(negedge clk); end
    rst_n = 0;
    #1;
    check("arst_busy", s_busy, 0);
    check("arst_done", s_done, 0);
    check("arst_hi", s_hi, 0);
    check("arst_lo", s_lo, 0);
    hm = 0; lm = 0;
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    do_mul32(1, 32'hFFFFFFFF, 32'h00000005, 0);

    for (int i = 0; i < 120; i++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: ra = 32'h80000000;
        1: rb = 32'hFFFFFFFF;
        2: ra = 32'h0;
        default: ;
      endcase
      do_mul32(1'($urandom_range(0, 1)), ra, rb, 0);
    end

    @(negedge clk);
    for (int sg = 0; sg < 2; sg++)
      for (int a = 0; a < 16; a++)
        for (int b = 0; b < 16; b++)
          do_mul4(1'(sg), 4'(a), 4'(b));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
